wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset; one clock; asynchronous, active-low.
REQ-004 SHALL have ex_valid  input  1  execute stage presents a retiring instruction.
REQ-005 SHALL have ex_ready  output  1  stage can accept; transfer when ex_valid && ex_ready.
REQ-006 SHALL have ex_rd  input  5  destination register index.
REQ-007 SHALL have ex_result  input  WIDTH  ALU result (non-load write data).
REQ-008 SHALL have ex_reg_write  input  1  instruction writes rd.
REQ-009 SHALL have ex_is_load  input  1  instruction is a load.
REQ-010 SHALL have ex_funct3  input  3  load size/sign code.
REQ-011 SHALL have ex_addr_lo  input  2  load address bits [1:0].
REQ-012 SHALL have mem_rvalid  input  1  data-memory read response valid (one-cycle pulse).
REQ-013 SHALL have mem_rdata  input  WIDTH  raw aligned memory word.
REQ-014 SHALL have RegWrite  output  1  register-file write enable, registered.
REQ-015 SHALL have rd  output  5  register-file write address, registered.
REQ-016 SHALL have WD  output  WIDTH  register-file write data, registered.
REQ-017 SHALL have busy  output  1  high while a load awaits its response.

Function
REQ-018 SHALL implement FSM states IDLE and WAIT_MEM; ex_ready = (state == IDLE); busy = (state == WAIT_MEM).
REQ-019 IDLE, accept of a non-load SHALL, next cycle, drive RegWrite = ex_reg_write && (ex_rd != 0), rd = ex_rd, WD = ex_result; state stays IDLE; throughput one per cycle.
REQ-020 IDLE, accept of a load SHALL latch rd, funct3 and addr_lo, go to WAIT_MEM, and drive RegWrite = 0 the next cycle.
REQ-021 WAIT_MEM, mem_rvalid = 1 SHALL, next cycle, drive RegWrite = (latched rd != 0), WD = extended load data, and return to IDLE; ex_ready is high in that cycle.
REQ-022 WAIT_MEM, mem_rvalid = 0 SHALL hold state with RegWrite = 0, indefinitely.
REQ-023 mem_rvalid in IDLE SHALL be ignored, including the cycle a load is accepted.
REQ-024 RegWrite SHALL be a single-cycle pulse per retired write; it is 0 in every cycle with no completing write.
REQ-025 Extension: 000 LB selects byte addr_lo, sign-extended; 100 LBU selects the same byte, zero-extended; 001 LH selects halfword addr_lo[1], sign-extended; 101 LHU selects that halfword, zero-extended; 010 and all other codes pass the full word.
REQ-026 Halfword select SHALL ignore addr_lo[0]; no misalignment trap.
REQ-027 rd = 0 SHALL never produce RegWrite = 1; rd and WD still update.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, RegWrite 0, rd 0, WD 0, and latched load fields 0.
REQ-029 Reset during WAIT_MEM SHALL drop the pending load; no write occurs for it after release.
REQ-030 After rst_n rises, ex_ready SHALL be 1 in the first cycle.

Configuration
REQ-031 Macro WB_FWD_EN defined SHALL add outputs fwd_valid (1), fwd_rd (5), fwd_data (WIDTH) equal to RegWrite, rd and WD, plus ld_pending (1) = busy and ld_rd (5) = latched load rd (0 when not pending).
REQ-032 Without WB_FWD_EN, those ports SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Non-load: ex_rd=5, ex_result=0x1234_5678, ex_reg_write=1 accepted at cycle N -> cycle N+1: RegWrite=1, rd=5, WD=0x1234_5678; cycle N+2: RegWrite=0.
REQ-034 LB sign: load rd=7, funct3=000, addr_lo=2, mem_rdata=0x0080_0000 after 3 wait cycles -> ex_ready=0 and RegWrite=0 while waiting; cycle after rvalid: RegWrite=1, rd=7, WD=0xFFFF_FF80.
REQ-035 LHU: funct3=101, addr_lo=3, mem_rdata=0xBEEF_1234 -> WD=0x0000_BEEF; LH with addr_lo=0 -> WD=0x0000_1234.
REQ-036 rd=0: non-load with ex_reg_write=1 and load with rd=0 -> RegWrite never 1; spurious mem_rvalid in IDLE -> no write, state unchanged.
REQ-037 Reset mid-load: rst_n low in WAIT_MEM, then mem_rvalid after release -> no RegWrite; ex_ready=1; ld_pending=0 when WB_FWD_EN is defined.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results directly and waits for load data, extending it to WIDTH.
// Optional macro WB_FWD_EN adds forwarding/pending-load observation ports.
module wb_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [4:0]       ex_rd,
  input  logic [WIDTH-1:0] ex_result,
  input  logic             ex_reg_write,
  input  logic             ex_is_load,
  input  logic [2:0]       ex_funct3,
  input  logic [1:0]       ex_addr_lo,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             RegWrite,
  output logic [4:0]       rd,
  output logic [WIDTH-1:0] WD,
  output logic             busy
`ifdef WB_FWD_EN
  ,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [WIDTH-1:0] fwd_data,
  output logic             ld_pending,
  output logic [4:0]       ld_rd
`endif
);

  localparam int unsigned RegIdxW = 5;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic                 reg_write_q, reg_write_d;
  logic [RegIdxW-1:0]   rd_q, rd_d;
  logic [WIDTH-1:0]     wd_q, wd_d;
  logic [RegIdxW-1:0]   ld_rd_q, ld_rd_d;
  logic [2:0]           ld_funct3_q, ld_funct3_d;
  logic [1:0]           ld_addr_q, ld_addr_d;

  // Select and extend the addressed byte/halfword; halfword select ignores addr[0].
  function automatic logic [WIDTH-1:0] load_extend(input logic [2:0]       funct3,
                                                   input logic [1:0]       addr,
                                                   input logic [WIDTH-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (addr)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  load_extend = {{(WIDTH-8){b[7]}}, b};
      3'b100:  load_extend = {{(WIDTH-8){1'b0}}, b};
      3'b001:  load_extend = {{(WIDTH-16){h[15]}}, h};
      3'b101:  load_extend = {{(WIDTH-16){1'b0}}, h};
      default: load_extend = word;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wd_q        <= '0;
      ld_rd_q     <= '0;
      ld_funct3_q <= '0;
      ld_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wd_q        <= wd_d;
      ld_rd_q     <= ld_rd_d;
      ld_funct3_q <= ld_funct3_d;
      ld_addr_q   <= ld_addr_d;
    end
  end

  // Next-state: RegWrite defaults low so it only pulses on a completing write.
  always_comb begin
    state_d     = state_q;
    reg_write_d = 1'b0;
    rd_d        = rd_q;
    wd_d        = wd_q;
    ld_rd_d     = ld_rd_q;
    ld_funct3_d = ld_funct3_q;
    ld_addr_d   = ld_addr_q;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (ex_is_load) begin
            ld_rd_d     = ex_rd;
            ld_funct3_d = ex_funct3;
            ld_addr_d   = ex_addr_lo;
            state_d     = WAIT_MEM;
          end else begin
            reg_write_d = ex_reg_write && (ex_rd != '0);
            rd_d        = ex_rd;
            wd_d        = ex_result;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          reg_write_d = (ld_rd_q != '0);
          rd_d        = ld_rd_q;
          wd_d        = load_extend(ld_funct3_q, ld_addr_q, mem_rdata);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ex_ready = (state_q == IDLE);
  assign busy     = (state_q == WAIT_MEM);
  assign RegWrite = reg_write_q;
  assign rd       = rd_q;
  assign WD       = wd_q;

`ifdef WB_FWD_EN
  assign fwd_valid  = reg_write_q;
  assign fwd_rd     = rd_q;
  assign fwd_data   = wd_q;
  assign ld_pending = busy;
  assign ld_rd      = busy ? ld_rd_q : RegIdxW'(0);
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus queues expected writes, a negedge monitor retires them.
module tb_wb_stage;

  localparam int unsigned W = 32;

  typedef struct {
    logic [4:0]   rd;
    logic [W-1:0] wd;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ex_valid, ex_ready, ex_reg_write, ex_is_load;
  logic [4:0]   ex_rd;
  logic [W-1:0] ex_result;
  logic [2:0]   ex_funct3;
  logic [1:0]   ex_addr_lo;
  logic         mem_rvalid;
  logic [W-1:0] mem_rdata;
  logic         RegWrite, busy;
  logic [4:0]   rd;
  logic [W-1:0] WD;
`ifdef WB_FWD_EN
  logic         fwd_valid, ld_pending;
  logic [4:0]   fwd_rd, ld_rd;
  logic [W-1:0] fwd_data;
`endif

  int checks = 0;
  int failures = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  wb_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_result(ex_result),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_funct3(ex_funct3),
    .ex_addr_lo(ex_addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .RegWrite(RegWrite), .rd(rd), .WD(WD), .busy(busy)
`ifdef WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .ld_pending(ld_pending), .ld_rd(ld_rd)
`endif
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every RegWrite pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got rd=%0d WD=0x%08h expected no write", rd, WD);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_rd", W'(rd), W'(e.rd));
        chk("wr_wd", WD, e.wd);
`ifdef WB_FWD_EN
        chk("fwd_data", fwd_data, e.wd);
`endif
      end
    end
  end

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_rd = '0; ex_result = '0; ex_reg_write = 1'b0;
    ex_is_load = 1'b0; ex_funct3 = '0; ex_addr_lo = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic alu(input logic [4:0] r, input logic [W-1:0] res, input logic rw);
    chk("alu_ex_ready", W'(ex_ready), W'(1));
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = r; ex_result = res; ex_reg_write = rw;
    if (rw && r != 5'd0) exp_q.push_back('{rd: r, wd: res});
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic load(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] alo,
                      input logic [W-1:0] word, input logic [W-1:0] exp_wd, input int waits);
    chk("ld_ex_ready", W'(ex_ready), W'(1));
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = r; ex_funct3 = f3; ex_addr_lo = alo;
    ex_reg_write = 1'b1; ex_result = 32'h5555_5555;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_is_load = 1'b0;
    for (int i = 0; i < waits; i++) begin
      chk("wait_ex_ready", W'(ex_ready), W'(0));
      chk("wait_regwrite", W'(RegWrite), W'(0));
      @(posedge clk); #1;
    end
    chk("wait_busy", W'(busy), W'(1));
    mem_rvalid = 1'b1; mem_rdata = word;
    if (r != 5'd0) exp_q.push_back('{rd: r, wd: exp_wd});
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0;
    chk("done_ex_ready", W'(ex_ready), W'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_regwrite", W'(RegWrite), W'(0));
    chk("rst_rd", W'(rd), W'(0));
    chk("rst_wd", WD, W'(0));
    chk("rst_ex_ready", W'(ex_ready), W'(1));
    chk("rst_busy", W'(busy), W'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single non-load and its one-cycle pulse
    alu(5'd5, 32'h1234_5678, 1'b1);
    @(posedge clk); #1;
    chk("pulse_drop", W'(RegWrite), W'(0));

    // Back-to-back non-loads, no-write and rd=0 cases
    alu(5'd1, 32'h0000_000A, 1'b1);
    alu(5'd2, 32'h0000_000B, 1'b1);
    alu(5'd31, 32'hFFFF_FFFF, 1'b1);
    alu(5'd3, 32'hAAAA_0000, 1'b0);
    alu(5'd0, 32'h0BAD_0BAD, 1'b1);
    @(posedge clk); #1;
    chk("rd0_updates_rd", W'(rd), W'(0));
    chk("rd0_updates_wd", WD, 32'h0BAD_0BAD);
    chk("rd0_no_write", W'(RegWrite), W'(0));

    // Loads across extension codes
    load(5'd7,  3'b000, 2'd2, 32'h0080_0000, 32'hFFFF_FF80, 3);
    load(5'd8,  3'b101, 2'd3, 32'hBEEF_1234, 32'h0000_BEEF, 1);
    load(5'd9,  3'b001, 2'd0, 32'hBEEF_1234, 32'h0000_1234, 0);
    load(5'd10, 3'b100, 2'd1, 32'h0000_9A00, 32'h0000_009A, 2);
    load(5'd11, 3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001, 1);
    load(5'd12, 3'b010, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    load(5'd13, 3'b011, 2'd3, 32'hCAFE_F00D, 32'hCAFE_F00D, 1);
    load(5'd14, 3'b000, 2'd0, 32'h1234_567F, 32'h0000_007F, 0);
    load(5'd15, 3'b000, 2'd3, 32'h8000_0000, 32'hFFFF_FF80, 0);
    load(5'd16, 3'b100, 2'd3, 32'hFE00_0000, 32'h0000_00FE, 0);
    load(5'd0,  3'b010, 2'd0, 32'h1111_1111, 32'h1111_1111, 1);
    alu(5'd20, 32'h0000_2020, 1'b1);

    // Spurious rvalid in IDLE
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("spur_ex_ready", W'(ex_ready), W'(1));
    chk("spur_regwrite", W'(RegWrite), W'(0));

    // rvalid coincident with load accept is ignored
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd21; ex_funct3 = 3'b010; ex_addr_lo = 2'd0;
    mem_rvalid = 1'b1; mem_rdata = 32'h6666_6666;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_is_load = 1'b0; mem_rvalid = 1'b0;
    chk("coinc_busy", W'(busy), W'(1));
    chk("coinc_regwrite", W'(RegWrite), W'(0));
`ifdef WB_FWD_EN
    chk("fwd_ld_pending", W'(ld_pending), W'(1));
    chk("fwd_ld_rd", W'(ld_rd), W'(21));
`endif
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h4242_4242;
    exp_q.push_back('{rd: 5'd21, wd: 32'h4242_4242});
    @(posedge clk); #1;
    mem_rvalid = 1'b0;

    // Reset while a load is pending drops it
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd22; ex_funct3 = 3'b010;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_is_load = 1'b0;
    chk("prerst_busy", W'(busy), W'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ex_ready", W'(ex_ready), W'(1));
    chk("midrst_regwrite", W'(RegWrite), W'(0));
    @(negedge clk); rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h9999_9999;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("postrst_ex_ready", W'(ex_ready), W'(1));
    chk("postrst_regwrite", W'(RegWrite), W'(0));
`ifdef WB_FWD_EN
    chk("postrst_ld_pending", W'(ld_pending), W'(0));
    chk("postrst_ld_rd", W'(ld_rd), W'(0));
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", W'(exp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
